instr_queue: RTL and testbench
==============================

Name: instr_queue

Overview:
- Parametrised halfword-granular instruction queue between the fetch stage and the decode stage.
- Decouples fetch from decode stalls and realigns mixed 16/32-bit (RVC) instructions across fetch-word boundaries.
- Presents exactly one whole instruction per cycle to decode, with pc, npc and fetch exception attached.
- Supersedes the fixed one-word fetch-to-decode hand-off; adds buffering, back-pressure and misaligned-target handling.

Parameters:
- XLEN, 32, width of pc, npc and etval.
- DEPTH, 8, queue capacity in 16-bit halfwords; power of two, at least 4.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low.
- flush  in  1  discard all contents (jump, exception, mret).
- in_valid  in  1  fetch word offered.
- in_ready  out  1  queue can accept a word this cycle.
- in_pc  in  XLEN  fetch address; bit 1 set means only the upper halfword is valid.
- in_instr  in  32  fetch word, little-endian halfwords.
- in_exception  in  1  fetch fault for this word.
- in_ecause  in  4  fault cause.
- out_valid  out  1  complete instruction or fault available.
- out_ready  in  1  decode consumes the head this cycle.
- out_pc  out  XLEN  instruction address.
- out_npc  out  XLEN  out_pc+2 for compressed, out_pc+4 otherwise.
- out_instr  out  32  instruction; upper 16 bits zero when compressed.
- out_exception  out  1  head carries a fetch fault.
- out_ecause  out  4  fault cause.
- out_etval  out  XLEN  pc of the faulting halfword.

Behaviour:
- Storage:
  - Circular buffer of DEPTH entries: {data[15:0], pc, exc, ecause}.
  - Head and tail pointers of log2(DEPTH) bits, wrapping modulo DEPTH.
  - count of log2(DEPTH)+1 bits.
- Reset (rst=0, asynchronous): pointers=0, count=0, all entries cleared.
  - Outputs while in reset: in_ready=1, out_valid=0, all other outputs 0.
- in_ready = (count <= DEPTH-2). It is registered-state-derived and independent of out_ready in the same cycle.
- Push, when in_valid & in_ready & !flush:
  - in_pc[1]=0: write two entries, lower halfword then upper. pcs are in_pc and in_pc+2.
  - in_pc[1]=1: write one entry (upper halfword) with pc = in_pc.
  - Both entries take exc=in_exception and ecause=in_ecause.
- Head decode (combinational from registered state only):
  - h0 = entry[head], h1 = entry[head+1 mod DEPTH].
  - h0.exc=1: out_valid=(count>=1); out_exception=1; out_etval=h0.pc; out_instr=0; consumes 1 entry.
  - h0.data[1:0]!=2'b11: compressed. out_valid=(count>=1); out_instr={16'h0,h0.data}; consumes 1 entry.
  - Otherwise 32-bit. out_valid=(count>=2); out_instr={h1.data,h0.data}; consumes 2 entries.
  - 32-bit with h1.exc=1 (fault on the second half): out_exception=1, out_ecause=h1.ecause, out_etval=h1.pc, out_instr=0; consumes 2 entries.
  - out_pc=h0.pc in all cases. out_npc follows the compressed/32-bit classification even when faulting.
  - When out_valid=0, all out_* data ports are driven 0.
- Pop: when out_valid & out_ready, head advances by 1 or 2 and count decrements by the same amount.
- Push and pop in the same cycle are both performed; count_next = count + pushed - popped.
- Latency: a word pushed in cycle N is visible at the outputs in cycle N+1. No combinational path from in_* to out_*.
- Flush dominates:
  - Same-cycle push and pop are ignored.
  - Next cycle: count=0, head=tail=0, out_valid=0.
  - A fetch word presented together with flush is dropped.
- A 32-bit instruction with only its lower half queued holds out_valid=0 until its upper half arrives. There is no timeout.
- Full (count=DEPTH-1 or DEPTH): in_ready=0. Fetch must hold the word.
- Reset asserted mid-operation clears everything asynchronously. There is no partial-state recovery.

Decomposition:
- wires package:
  - instr_queue_entry_type (data, pc, exc, ecause).
  - instr_queue_in_type and instr_queue_out_type port records, matching the existing *_in_type/*_out_type style.
- constants package:
  - init_instr_queue_entry.
  - The RVC length-detect constant 2'b11.
- No sub-module; the storage is a flat register array inside the block. An optional sub-module rvc_length (1-bit classifier) is permitted but not required.

Test Plan:
- Aligned stream: push 0x00A00093 at pc 0x100, then 0x00B00113 at pc 0x104, out_ready=1. Expect outputs from cycle N+1: pc 0x100/npc 0x104, then pc 0x104/npc 0x108.
- Mixed RVC: push word 0x0505_4501 at pc 0x200. Expect two compressed instructions, 0x4501 at pc 0x200/npc 0x202 and 0x0505 at pc 0x202/npc 0x204.
- Straddle: push 0x0093_4501 at pc 0x300, then 0x0000_00A0 at pc 0x304. Expect:
  - 0x4501 at pc 0x300.
  - 32-bit 0x00A00093 at pc 0x302/npc 0x306, with out_valid=0 until the second word arrives.
- Misaligned target: push in_pc=0x402, in_instr=0x4581_xxxx. Expect a single compressed 0x4581 at pc 0x402; count returns to 0.
- Fault in the upper half: 32-bit head at pc 0x5FE, second word pushed at pc 0x600 with in_exception=1, ecause=1. Expect out_exception=1, out_ecause=1, out_etval=0x600, out_pc=0x5FE; 2 entries consumed.
- Full and flush: with DEPTH=8 and out_ready=0, push 4 aligned words. Expect in_ready=0 once count=8. Then assert flush with in_valid=1: the word is dropped, and the next cycle shows count=0, out_valid=0, in_ready=1.

Source files
------------

// File: rtl/instr_queue_pkg.sv
// rtl/instr_queue_pkg.sv - instr_queue shared types and constants
package instr_queue_pkg;

    localparam int IQ_XLEN = 32;

    // Halfwords whose low two bits are 2'b11 start a 32-bit instruction.
    localparam logic [1:0] RVC_LEN_32 = 2'b11;

    typedef struct packed {
        logic [15:0]        data;
        logic [IQ_XLEN-1:0] pc;
        logic               exc;
        logic [3:0]         ecause;
    } instr_queue_entry_type;

    localparam instr_queue_entry_type init_instr_queue_entry = '0;

    typedef struct packed {
        logic               flush;
        logic               in_valid;
        logic [IQ_XLEN-1:0] in_pc;
        logic [31:0]        in_instr;
        logic               in_exception;
        logic [3:0]         in_ecause;
        logic               out_ready;
    } instr_queue_in_type;

    typedef struct packed {
        logic               in_ready;
        logic               out_valid;
        logic [IQ_XLEN-1:0] out_pc;
        logic [IQ_XLEN-1:0] out_npc;
        logic [31:0]        out_instr;
        logic               out_exception;
        logic [3:0]         out_ecause;
        logic [IQ_XLEN-1:0] out_etval;
    } instr_queue_out_type;

    function automatic logic is_rvc(input logic [15:0] hw);
        return hw[1:0] != RVC_LEN_32;
    endfunction

endpackage

// File: rtl/instr_queue.sv
// rtl/instr_queue.sv - halfword-granular fetch-to-decode instruction queue with RVC realignment
module instr_queue
    import instr_queue_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [31:0]     in_instr,
    input  logic            in_exception,
    input  logic [3:0]      in_ecause,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_npc,
    output logic [31:0]     out_instr,
    output logic            out_exception,
    output logic [3:0]      out_ecause,
    output logic [XLEN-1:0] out_etval
);

    localparam int PW = $clog2(DEPTH);

    typedef struct packed {
        logic [15:0]     data;
        logic [XLEN-1:0] pc;
        logic            exc;
        logic [3:0]      ecause;
    } entry_t;

    entry_t          q [DEPTH];
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [PW:0]     count;

    entry_t          h0;
    entry_t          h1;
    logic            h0_rvc;
    logic            do_push;
    logic            do_pop;
    logic [1:0]      push_n;
    logic [1:0]      pop_n;

    assign h0     = q[head];
    assign h1     = q[head + PW'(1)];
    assign h0_rvc = is_rvc(h0.data);

    assign in_ready = (count <= (PW+1)'(DEPTH - 2));
    assign do_push  = in_valid && in_ready && !flush;
    assign push_n   = in_pc[1] ? 2'd1 : 2'd2;
    assign do_pop   = out_valid && out_ready && !flush;

    // Head decode looks only at registered entries, so fetch never reaches decode in the same cycle.
    always_comb begin
        out_valid     = 1'b0;
        out_pc        = '0;
        out_npc       = '0;
        out_instr     = '0;
        out_exception = 1'b0;
        out_ecause    = '0;
        out_etval     = '0;
        pop_n         = 2'd1;
        if (h0.exc) begin
            out_valid     = (count >= (PW+1)'(1));
            out_exception = 1'b1;
            out_ecause    = h0.ecause;
            out_etval     = h0.pc;
        end else if (h0_rvc) begin
            out_valid = (count >= (PW+1)'(1));
            out_instr = {16'h0, h0.data};
        end else begin
            out_valid = (count >= (PW+1)'(2));
            pop_n     = 2'd2;
            if (h1.exc) begin
                out_exception = 1'b1;
                out_ecause    = h1.ecause;
                out_etval     = h1.pc;
            end else begin
                out_instr = {h1.data, h0.data};
            end
        end
        if (out_valid) begin
            out_pc  = h0.pc;
            out_npc = h0.pc + (h0_rvc ? XLEN'(2) : XLEN'(4));
        end else begin
            out_instr     = '0;
            out_exception = 1'b0;
            out_ecause    = '0;
            out_etval     = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q[i] <= '0;
            end
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                if (in_pc[1]) begin
                    q[tail] <= '{data: in_instr[31:16], pc: in_pc,
                                 exc: in_exception, ecause: in_ecause};
                end else begin
                    q[tail]          <= '{data: in_instr[15:0], pc: in_pc,
                                          exc: in_exception, ecause: in_ecause};
                    q[tail + PW'(1)] <= '{data: in_instr[31:16], pc: in_pc + XLEN'(2),
                                          exc: in_exception, ecause: in_ecause};
                end
                tail <= tail + PW'(push_n);
            end
            if (do_pop) begin
                head <= head + PW'(pop_n);
            end
            count <= count + (do_push ? (PW+1)'(push_n) : '0)
                           - (do_pop  ? (PW+1)'(pop_n)  : '0);
        end
    end

endmodule

// File: tb/tb_instr_queue.sv
// tb/tb_instr_queue.sv - scoreboard bench for instr_queue
module tb_instr_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_pc = '0;
    logic [31:0] in_instr = '0;
    logic        in_exception = 1'b0;
    logic [3:0]  in_ecause = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_pc;
    logic [31:0] out_npc;
    logic [31:0] out_instr;
    logic        out_exception;
    logic [3:0]  out_ecause;
    logic [31:0] out_etval;

    int checks = 0;
    int fails  = 0;

    // {pc, npc, instr, exc, ecause, etval}
    typedef logic [132:0] rsp_t;
    rsp_t sb [$];

    instr_queue #(.XLEN(32), .DEPTH(8)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_instr(in_instr), .in_exception(in_exception), .in_ecause(in_ecause),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_npc(out_npc), .out_instr(out_instr), .out_exception(out_exception),
        .out_ecause(out_ecause), .out_etval(out_etval)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [132:0] act, input logic [132:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_rsp(input logic [31:0] pc, input logic [31:0] npc, input logic [31:0] ins,
                              input logic exc, input logic [3:0] ec, input logic [31:0] etval);
        sb.push_back({pc, npc, ins, exc, ec, etval});
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] w, input logic e, input logic [3:0] c);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1; in_pc = pc; in_instr = w; in_exception = e; in_ecause = c;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            fails++;
            $display("FAIL push_timeout: in_ready=%b expected 1 for pc %h", in_ready, pc);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("drain", 133'(sb.size()), 133'(0));
    endtask

    // Monitor: every accepted instruction must match the oldest expected response.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_out", {out_pc, out_npc, out_instr, out_exception, out_ecause, out_etval}, '0);
            end else begin
                chk("out_rsp", {out_pc, out_npc, out_instr, out_exception, out_ecause, out_etval},
                    sb.pop_front());
            end
        end
    end

    initial begin
        #1;
        chk("reset_outputs", {in_ready, out_valid, out_pc, out_instr}, {1'b1, 1'b0, 32'h0, 32'h0});
        @(negedge clk);
        rst = 1'b1;

        // Aligned stream
        expect_rsp(32'h100, 32'h104, 32'h00A00093, 1'b0, 4'h0, 32'h0);
        expect_rsp(32'h104, 32'h108, 32'h00B00113, 1'b0, 4'h0, 32'h0);
        push(32'h100, 32'h00A00093, 1'b0, 4'h0);
        chk("latency_n1", {32'h0, out_valid, out_pc}, {32'h0, 1'b1, 32'h100});
        push(32'h104, 32'h00B00113, 1'b0, 4'h0);
        drain();

        // Mixed RVC
        expect_rsp(32'h200, 32'h202, 32'h00004501, 1'b0, 4'h0, 32'h0);
        expect_rsp(32'h202, 32'h204, 32'h00000505, 1'b0, 4'h0, 32'h0);
        push(32'h200, 32'h05054501, 1'b0, 4'h0);
        drain();

        // Straddle across fetch words
        expect_rsp(32'h300, 32'h302, 32'h00004501, 1'b0, 4'h0, 32'h0);
        expect_rsp(32'h302, 32'h306, 32'h00A00093, 1'b0, 4'h0, 32'h0);
        expect_rsp(32'h306, 32'h308, 32'h00000000, 1'b0, 4'h0, 32'h0);
        push(32'h300, 32'h00934501, 1'b0, 4'h0);
        @(negedge clk);
        @(negedge clk);
        chk("straddle_wait", 133'(out_valid), 133'(0));
        push(32'h304, 32'h000000A0, 1'b0, 4'h0);
        drain();

        // Misaligned target
        expect_rsp(32'h402, 32'h404, 32'h00004581, 1'b0, 4'h0, 32'h0);
        push(32'h402, 32'h45811234, 1'b0, 4'h0);
        drain();
        chk("misaligned_empty", {in_ready, out_valid}, {1'b1, 1'b0});

        // Fault on the upper half of a 32-bit instruction
        expect_rsp(32'h5FE, 32'h602, 32'h0, 1'b1, 4'h1, 32'h600);
        expect_rsp(32'h602, 32'h604, 32'h0, 1'b1, 4'h1, 32'h602);
        push(32'h5FE, 32'h00930000, 1'b0, 4'h0);
        @(negedge clk);
        chk("half_wait", 133'(out_valid), 133'(0));
        push(32'h600, 32'h12345678, 1'b1, 4'h1);
        drain();

        // Full then flush with a fetch word present
        @(posedge clk);
        #1 out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push(32'h700 + 32'(i * 4), 32'h00A00093, 1'b0, 4'h0);
        end
        @(negedge clk);
        chk("full", {in_ready, out_valid}, {1'b0, 1'b1});
        in_valid = 1'b1; in_pc = 32'h710; in_instr = 32'h00000013; flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("after_flush", {in_ready, out_valid}, {1'b1, 1'b0});

        // Queue restarts cleanly after flush
        expect_rsp(32'h800, 32'h804, 32'h00000013, 1'b0, 4'h0, 32'h0);
        push(32'h800, 32'h00000013, 1'b0, 4'h0);
        drain();

        // Asynchronous reset mid-operation
        @(posedge clk);
        #1 out_ready = 1'b0;
        push(32'h900, 32'h00000013, 1'b0, 4'h0);
        @(negedge clk);
        chk("pre_reset_valid", 133'(out_valid), 133'(1));
        #2 rst = 1'b0;
        #1 chk("async_reset", {in_ready, out_valid, out_pc}, {1'b1, 1'b0, 32'h0});
        @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("post_reset", {in_ready, out_valid}, {1'b1, 1'b0});
        chk("sb_empty", 133'(sb.size()), 133'(0));

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
